// File: rtl/decode_issue_if.sv
// Instruction, writeback and issue signals of decode_issue bundled as one interface.
// The slave modport is the decoder side; the master modport is the fetch/ALU/writeback side.
interface decode_issue_if #(
    parameter int DATA_WIDTH = 31
);
    logic                  i_instr_valid;
    logic                  o_instr_ready;
    logic [31:0]           i_instr;
    logic                  i_wb_en;
    logic [4:0]            i_wb_addr;
    logic [DATA_WIDTH:0]   i_wb_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [6:0]            o_opcode;
    logic [6:0]            o_funct7;
    logic [2:0]            o_funct3;
    logic [DATA_WIDTH:0]   o_rs1_data;
    logic [DATA_WIDTH:0]   o_rs2_data;
    logic [31:0]           o_imm;
    logic [4:0]            o_rd_addr;
    logic                  o_illegal;

    modport slave (
        input  i_instr_valid, i_instr, i_wb_en, i_wb_addr, i_wb_data, i_ready,
        output o_instr_ready, o_valid, o_opcode, o_funct7, o_funct3,
               o_rs1_data, o_rs2_data, o_imm, o_rd_addr, o_illegal
    );

    modport master (
        output i_instr_valid, i_instr, i_wb_en, i_wb_addr, i_wb_data, i_ready,
        input  o_instr_ready, o_valid, o_opcode, o_funct7, o_funct3,
               o_rs1_data, o_rs2_data, o_imm, o_rd_addr, o_illegal
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: OP-IMM and R-type decode, register file, pending-write scoreboard.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback into the operands.
module decode_issue #(
    parameter int DATA_WIDTH = 31
) (
    input logic          clk,
    input logic          rst,
    input logic          clk_en,
    decode_issue_if.slave bus
);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    logic [DATA_WIDTH:0] rf [32];
    logic [31:0]         pending;

    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;
    logic [4:0]          rd, rs1, rs2;
    logic                is_imm, is_reg, legal;
    logic                byp1, byp2, busy1, busy2, hazard, accept;
    logic [DATA_WIDTH:0] rs1_val, rs2_val;
    logic [31:0]         set_mask, clr_mask;

    assign opcode = bus.i_instr[6:0];
    assign rd     = bus.i_instr[11:7];
    assign funct3 = bus.i_instr[14:12];
    assign rs1    = bus.i_instr[19:15];
    assign rs2    = bus.i_instr[24:20];
    assign funct7 = bus.i_instr[31:25];
    assign is_imm = (opcode == OP_IMM);
    assign is_reg = (opcode == OP_REG);

    always_comb begin
        legal = 1'b0;
        if (is_imm) begin
            case (funct3)
                3'b001:  legal = (funct7 == 7'h00);
                3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                default: legal = 1'b1;
            endcase
        end else if (is_reg) begin
            legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end
    end

`ifdef DECODE_BYPASS_EN
    assign byp1 = bus.i_wb_en && (bus.i_wb_addr == rs1) && (rs1 != 5'd0);
    assign byp2 = bus.i_wb_en && (bus.i_wb_addr == rs2) && (rs2 != 5'd0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // A pending source that is being forwarded this cycle is not a hazard.
    assign busy1  = (rs1 != 5'd0) && pending[rs1] && !byp1;
    assign busy2  = is_reg && (rs2 != 5'd0) && pending[rs2] && !byp2;
    assign hazard = bus.i_instr_valid && legal && (busy1 || busy2);

    assign bus.o_instr_ready = (!bus.o_valid || bus.i_ready) && !hazard;
    assign accept            = bus.i_instr_valid && bus.o_instr_ready && clk_en;

    assign rs1_val = (rs1 == 5'd0) ? '0 : (byp1 ? bus.i_wb_data : rf[rs1]);
    assign rs2_val = (rs2 == 5'd0) ? '0 : (byp2 ? bus.i_wb_data : rf[rs2]);

    assign clr_mask = bus.i_wb_en ? (32'd1 << bus.i_wb_addr) : 32'd0;
    assign set_mask = (accept && legal && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (clk_en) begin
            // OR-ing the set mask last lets a new producer win over a same-edge retire.
            pending <= (pending & ~clr_mask) | set_mask;
            if (bus.i_wb_en && (bus.i_wb_addr != 5'd0))
                rf[bus.i_wb_addr] <= bus.i_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_valid    <= 1'b0;
            bus.o_opcode   <= '0;
            bus.o_funct7   <= '0;
            bus.o_funct3   <= '0;
            bus.o_rs1_data <= '0;
            bus.o_rs2_data <= '0;
            bus.o_imm      <= '0;
            bus.o_rd_addr  <= '0;
            bus.o_illegal  <= 1'b0;
        end else if (clk_en) begin
            if (accept) begin
                bus.o_valid    <= 1'b1;
                bus.o_opcode   <= opcode;
                bus.o_funct7   <= funct7;
                bus.o_funct3   <= funct3;
                bus.o_rd_addr  <= legal ? rd : 5'd0;
                bus.o_imm      <= (legal && is_imm) ? {{20{bus.i_instr[31]}}, bus.i_instr[31:20]} : 32'd0;
                bus.o_rs1_data <= legal ? rs1_val : '0;
                bus.o_rs2_data <= (legal && is_reg) ? rs2_val : '0;
                bus.o_illegal  <= !legal;
            end else if (bus.i_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Randomized bench for decode_issue with a queue/array-level reference model of
// the decode rules, register file and pending-write set.
module tb_decode_issue;
    localparam int DW = 31;

    logic clk = 1'b0;
    logic rst, clk_en;
    always #5 clk = ~clk;

    decode_issue_if #(.DATA_WIDTH(DW)) bus ();
    decode_issue #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus));

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // reference model state
    logic [DW:0] m_rf [32];
    bit          m_pend [32];
    bit          m_valid;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [DW:0] m_d1, m_d2;
    logic [31:0] m_imm;
    logic [4:0]  m_rd;
    bit          m_ill;

    function automatic bit is_legal(input logic [31:0] ins);
        logic [6:0] f7 = ins[31:25];
        logic [2:0] f3 = ins[14:12];
        case (ins[6:0])
            7'h13:   return !((f3 == 3'd1 && f7 != 7'h00) ||
                              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
            7'h33:   return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit fwd(input logic [4:0] r);
`ifdef DECODE_BYPASS_EN
        return bus.i_wb_en && bus.i_wb_addr == r && r != 5'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW:0] operand(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (fwd(r)) return bus.i_wb_data;
        return m_rf[r];
    endfunction

    function automatic bit model_ready();
        logic [31:0] ins = bus.i_instr;
        bit isr = (ins[6:0] == 7'h33);
        bit b1 = ins[19:15] != 0 && m_pend[ins[19:15]] && !fwd(ins[19:15]);
        bit b2 = isr && ins[24:20] != 0 && m_pend[ins[24:20]] && !fwd(ins[24:20]);
        bit haz = bus.i_instr_valid && is_legal(ins) && (b1 || b2);
        return (!m_valid || bus.i_ready) && !haz;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_pend[i] = 0; end
        m_valid = 0; m_op = 0; m_f7 = 0; m_f3 = 0; m_d1 = 0; m_d2 = 0;
        m_imm = 0; m_rd = 0; m_ill = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, then return 1 time unit after the rising edge.
    task automatic cycle();
        bit rdy, acc, leg;
        logic [31:0] ins;
        @(negedge clk);
        rdy = model_ready();
        check("instr_ready", bus.o_instr_ready, rdy);
        check("valid", bus.o_valid, m_valid);
        if (m_valid) begin
            check("opcode", bus.o_opcode, m_op);
            check("funct7", bus.o_funct7, m_f7);
            check("funct3", bus.o_funct3, m_f3);
            check("rs1_data", bus.o_rs1_data, m_d1);
            check("rs2_data", bus.o_rs2_data, m_d2);
            check("imm", bus.o_imm, m_imm);
            check("rd_addr", bus.o_rd_addr, m_rd);
            check("illegal", bus.o_illegal, m_ill);
        end
        ins = bus.i_instr;
        leg = is_legal(ins);
        acc = bus.i_instr_valid && rdy && clk_en;
        if (rst) model_reset();
        else if (clk_en) begin
            if (acc) begin
                m_valid = 1; m_op = ins[6:0]; m_f7 = ins[31:25]; m_f3 = ins[14:12];
                m_ill = !leg;
                m_rd  = leg ? ins[11:7] : 5'd0;
                m_imm = (leg && ins[6:0] == 7'h13) ? 32'($signed(ins[31:20])) : 32'd0;
                m_d1  = leg ? operand(ins[19:15]) : '0;
                m_d2  = (leg && ins[6:0] == 7'h33) ? operand(ins[24:20]) : '0;
            end else if (bus.i_ready) m_valid = 0;
            if (bus.i_wb_en) m_pend[bus.i_wb_addr] = 0;
            if (acc && leg && ins[11:7] != 0) m_pend[ins[11:7]] = 1;
            if (bus.i_wb_en && bus.i_wb_addr != 0) m_rf[bus.i_wb_addr] = bus.i_wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0] f7;
        int k = $urandom_range(0, 9);
        if (k == 0) return r;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        return {f7, 2'b00, r[22:20], 2'b00, r[17:15], r[14:12], 2'b00, r[9:7],
                (k < 5) ? 7'h13 : 7'h33};
    endfunction

    initial begin
        rst = 1; clk_en = 1;
        bus.i_instr_valid = 0; bus.i_instr = 0; bus.i_ready = 1;
        bus.i_wb_en = 0; bus.i_wb_addr = 0; bus.i_wb_data = 0;
        model_reset();
        @(posedge clk); #1;
        cycle();
        rst = 0;
        check("rst_valid", bus.o_valid, 0);
        check("rst_imm", bus.o_imm, 0);
        check("rst_rs1", bus.o_rs1_data, 0);

        // ADDI x1,x0,5
        bus.i_instr_valid = 1; bus.i_instr = 32'h00500093;
        cycle();
        check("addi_valid", bus.o_valid, 1);
        check("addi_op", bus.o_opcode, 7'h13);
        check("addi_f3", bus.o_funct3, 0);
        check("addi_imm", bus.o_imm, 32'h5);
        check("addi_rs1", bus.o_rs1_data, 0);
        check("addi_rd", bus.o_rd_addr, 1);
        check("addi_ill", bus.o_illegal, 0);

        // ADDI x5,x0,-1
        bus.i_instr = 32'hFFF00293;
        cycle();
        check("neg_imm", bus.o_imm, 32'hFFFFFFFF);
        check("neg_rd", bus.o_rd_addr, 5);

        // downstream stall holds the issued instruction
        bus.i_ready = 0; bus.i_instr = 32'h00300313;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_imm", bus.o_imm, 32'hFFFFFFFF);
            check("hold_rd", bus.o_rd_addr, 5);
            check("hold_rdy", bus.o_instr_ready, 0);
        end
        bus.i_ready = 1;
        cycle();
        check("release_rd", bus.o_rd_addr, 6);

        // ADD x2,x1,x1 waits for x1
        bus.i_instr = 32'h00108133;
        cycle(); cycle();
        check("raw_stall", bus.o_instr_ready, 0);
        bus.i_wb_en = 1; bus.i_wb_addr = 1; bus.i_wb_data = 7;
        cycle();
        bus.i_wb_en = 0;
`ifdef DECODE_BYPASS_EN
        check("byp_rd", bus.o_rd_addr, 2);
`else
        check("nobyp_valid", bus.o_valid, 0);
        cycle();
`endif
        check("raw_rs1", bus.o_rs1_data, 7);
        check("raw_rs2", bus.o_rs2_data, 7);

        // illegal SLLI, then a reader of x3
        bus.i_instr = 32'h40109193;
        cycle();
        check("slli_ill", bus.o_illegal, 1);
        check("slli_rd", bus.o_rd_addr, 0);
        bus.i_instr = 32'h000183B3;
        check("x3_ready", bus.o_instr_ready, 1);
        cycle();
        check("x3_rd", bus.o_rd_addr, 7);

        // writeback to x0 is dropped
        bus.i_instr_valid = 0;
        bus.i_wb_en = 1; bus.i_wb_addr = 0; bus.i_wb_data = 32'hFFFFFFFF;
        cycle();
        bus.i_wb_en = 0; bus.i_instr_valid = 1; bus.i_instr = 32'h00000233;
        check("x0_ready", bus.o_instr_ready, 1);
        cycle();
        check("x0_rs1", bus.o_rs1_data, 0);
        check("x0_rs2", bus.o_rs2_data, 0);
        bus.i_instr_valid = 0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst               = ($urandom_range(0, 199) == 0);
            clk_en            = ($urandom_range(0, 9) != 0);
            bus.i_instr_valid = ($urandom_range(0, 9) < 7);
            bus.i_instr       = rand_instr();
            bus.i_ready       = ($urandom_range(0, 9) < 7);
            bus.i_wb_en       = ($urandom_range(0, 9) < 4);
            bus.i_wb_addr     = 5'($urandom_range(0, 7));
            bus.i_wb_data     = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
